// File: rtl/fifo_sp_1536x32_ctrl.sv
// rtl/fifo_sp_1536x32_ctrl.sv - 1536x32 FIFO controller over a single-port RAM with 2-entry prefetch
//
// Purpose: presents one ram_sp_1536x32 (single port, 1-cycle read latency) as a
// 1536-entry FIFO with a valid/ready output. Pushes and prefetch reads share the
// RAM port; under contention they alternate. A 2-entry prefetch buffer lets the
// output stream back-to-back.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push_i/push_dat_i    push request and data; accepted when push_i && push_rdy_o
//   push_rdy_o           space available (register-derived only, never looks at push_i)
//   out_val_o/out_dat_o  head of FIFO; consumed when out_val_o && out_rdy_i
//   out_rdy_i            consumer ready
//   level_o              words held: RAM + in-flight read + prefetch (0..DEPTH+2)
//   ram_*                one-to-one to the RAM adr_i/wr_ena_i/wr_dat_i/rd_ena_i/rd_dat_o
//
// Build option: FIFO_BYPASS_EN - when defined, a push into an otherwise empty
// RAM path goes straight into the prefetch buffer (1-cycle empty-to-valid).
module fifo_sp_1536x32_ctrl #(
  parameter int DEPTH  = 1536,
  parameter int ADR_WD = 11,
  parameter int DAT_WD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DAT_WD-1:0] push_dat_i,
  output logic              push_rdy_o,
  output logic              out_val_o,
  output logic [DAT_WD-1:0] out_dat_o,
  input  logic              out_rdy_i,
  output logic [ADR_WD-1:0] level_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [ADR_WD-1:0] LAST = ADR_WD'(DEPTH - 1);
  localparam logic [ADR_WD-1:0] FULL = ADR_WD'(DEPTH);
  localparam logic [ADR_WD-1:0] ONE  = ADR_WD'(1);

  logic [ADR_WD-1:0] wr_ptr, rd_ptr, ram_cnt, adr_q;
  logic              infl_r, pri_rd_r;
  logic [1:0]        pf_cnt;
  logic              pf_head, pf_tail;
  logic [DAT_WD-1:0] pf_mem [2];

  logic              read_want, push_acc, byp, wr_grant, rd_grant, pop, cap;
  logic [DAT_WD-1:0] cap_dat;

  // A read may only be issued if its data is guaranteed a prefetch slot when it lands.
  assign read_want  = (ram_cnt != '0) &&
                      ((pf_cnt == 2'd0) || ((pf_cnt == 2'd1) && !infl_r));
  assign push_rdy_o = (ram_cnt != FULL) && !(read_want && pri_rd_r);
  assign push_acc   = push_i && push_rdy_o;
  assign pop        = out_val_o && out_rdy_i;

`ifdef FIFO_BYPASS_EN
  // Only legal while nothing older sits in RAM or in flight, so order is kept.
  assign byp     = push_acc && (ram_cnt == '0) && !infl_r &&
                   ((pf_cnt != 2'd2) || pop);
  assign cap     = infl_r || byp;
  assign cap_dat = infl_r ? ram_rd_dat_i : push_dat_i;
`else
  assign byp     = 1'b0;
  assign cap     = infl_r;
  assign cap_dat = ram_rd_dat_i;
`endif

  assign wr_grant     = push_acc && !byp;
  assign rd_grant     = read_want && !wr_grant;
  assign ram_wr_ena_o = wr_grant;
  assign ram_rd_ena_o = rd_grant;
  assign ram_wr_dat_o = push_dat_i;
  // Address holds its last value on idle cycles to avoid needless toggling.
  assign ram_adr_o    = wr_grant ? wr_ptr : (rd_grant ? rd_ptr : adr_q);

  assign out_val_o = (pf_cnt != 2'd0);
  assign out_dat_o = pf_mem[pf_head];
  assign level_o   = ram_cnt + ADR_WD'(infl_r) + ADR_WD'(pf_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      adr_q     <= '0;
      infl_r    <= 1'b0;
      pri_rd_r  <= 1'b0;
      pf_cnt    <= 2'd0;
      pf_head   <= 1'b0;
      pf_tail   <= 1'b0;
      pf_mem[0] <= '0;
      pf_mem[1] <= '0;
    end else begin
      if (wr_grant) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ONE;
      if (rd_grant) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ONE;

      if (wr_grant)      ram_cnt <= ram_cnt + ONE;
      else if (rd_grant) ram_cnt <= ram_cnt - ONE;

      infl_r <= rd_grant;
      adr_q  <= ram_adr_o;

      // A write that beat a waiting read hands the next contended slot to the read.
      if (wr_grant && read_want) pri_rd_r <= 1'b1;
      else if (rd_grant)         pri_rd_r <= 1'b0;

      if (cap) begin
        pf_mem[pf_tail] <= cap_dat;
        pf_tail         <= ~pf_tail;
      end
      if (pop) pf_head <= ~pf_head;

      case ({cap, pop})
        2'b10:   pf_cnt <= pf_cnt + 2'd1;
        2'b01:   pf_cnt <= pf_cnt - 2'd1;
        default: pf_cnt <= pf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sp_1536x32_ctrl.sv
// tb/tb_fifo_sp_1536x32_ctrl.sv - self-checking bench for fifo_sp_1536x32_ctrl
module tb_fifo_sp_1536x32_ctrl;

  localparam int DEPTH = 1536;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_i;
  logic [31:0] push_dat_i;
  logic        push_rdy_o;
  logic        out_val_o;
  logic [31:0] out_dat_o;
  logic        out_rdy_i;
  logic [10:0] level_o;
  logic [10:0] ram_adr_o;
  logic        ram_wr_ena_o;
  logic [31:0] ram_wr_dat_o;
  logic        ram_rd_ena_o;
  logic [31:0] ram_rd_dat_i;

  int total = 0;
  int bad   = 0;

  fifo_sp_1536x32_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_i),
    .push_dat_i   (push_dat_i),
    .push_rdy_o   (push_rdy_o),
    .out_val_o    (out_val_o),
    .out_dat_o    (out_dat_o),
    .out_rdy_i    (out_rdy_i),
    .level_o      (level_o),
    .ram_adr_o    (ram_adr_o),
    .ram_wr_ena_o (ram_wr_ena_o),
    .ram_wr_dat_o (ram_wr_dat_o),
    .ram_rd_ena_o (ram_rd_ena_o),
    .ram_rd_dat_i (ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_ena_o && ram_adr_o < 11'(DEPTH)) mem[ram_adr_o] <= ram_wr_dat_o;
    if (ram_rd_ena_o && ram_adr_o < 11'(DEPTH)) ram_rd_dat_i <= mem[ram_adr_o];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FIFO contents as a plain queue of accepted words, plus the
  // expected next RAM write/read addresses walking 0..DEPTH-1 and wrapping.
  logic [31:0] q[$];
  int exp_wa, exp_ra;

  initial begin
    exp_wa = 0;
    exp_ra = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_wa = 0;
        exp_ra = 0;
      end else begin
        check("level", 32'(level_o), q.size());
        check("one_port", 32'(ram_wr_ena_o && ram_rd_ena_o), 0);
        if (ram_wr_ena_o) begin
          check("wr_adr", 32'(ram_adr_o), exp_wa);
          exp_wa = (exp_wa == DEPTH - 1) ? 0 : exp_wa + 1;
        end
        if (ram_rd_ena_o) begin
          check("rd_adr", 32'(ram_adr_o), exp_ra);
          exp_ra = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
        end
        if (out_val_o) begin
          if (q.size() == 0) check("val_when_empty", 32'(out_val_o), 0);
          else begin
            check("out_head", out_dat_o, q[0]);
            if (out_rdy_i) void'(q.pop_front());
          end
        end
        if (push_i && push_rdy_o) q.push_back(push_dat_i);
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base, input bit rnd, input int budget);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < budget) begin
      push_i = 1'b1;
      push_dat_i = base + 32'(k);
      if (rnd) out_rdy_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (push_rdy_o) k++;
      adv();
      cyc++;
    end
    push_i = 1'b0;
    check("push_count", k, n);
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    out_rdy_i = 1'b1;
    @(negedge clk);
    while (level_o != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_level", 32'(level_o), 0);
    adv();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_wr;
    int   k;
    rst = 1'b1; push_i = 1'b0; push_dat_i = '0; out_rdy_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_val",    32'(out_val_o), 0);
    check("rst_rdy",    32'(push_rdy_o), 1);
    check("rst_level",  32'(level_o), 0);
    check("rst_adr",    32'(ram_adr_o), 0);
    check("rst_ena",    32'({ram_wr_ena_o, ram_rd_ena_o}), 0);
    check("rst_dat",    out_dat_o, 0);
    adv();
    rst = 1'b0;

    // Single push through an empty FIFO: valid appears 3 cycles later.
    push_i = 1'b1; push_dat_i = 32'hA5A5_0001; out_rdy_i = 1'b1;
    @(negedge clk);
    check("t0_wr",  32'(ram_wr_ena_o), 1);
    check("t0_adr", 32'(ram_adr_o), 0);
    check("t0_dat", ram_wr_dat_o, 32'hA5A5_0001);
    adv(); push_i = 1'b0;
    @(negedge clk);
    check("t1_rd",  32'(ram_rd_ena_o), 1);
    check("t1_adr", 32'(ram_adr_o), 0);
    check("t1_val", 32'(out_val_o), 0);
    adv();
    @(negedge clk);
    check("t2_val", 32'(out_val_o), 0);
    check("t2_lvl", 32'(level_o), 1);
    adv();
    @(negedge clk);
    check("t3_val", 32'(out_val_o), 1);
    check("t3_dat", out_dat_o, 32'hA5A5_0001);
    adv();
    @(negedge clk);
    check("t4_lvl", 32'(level_o), 0);
    check("t4_val", 32'(out_val_o), 0);
    adv();

    // Fill to DEPTH+2 with the consumer stalled.
    out_rdy_i = 1'b0;
    push_words(1538, 32'd0, 1'b0, 3000);
    for (int i = 0; i < 3; i++) begin
      push_i = 1'b1; push_dat_i = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      check("full_rdy", 32'(push_rdy_o), 0);
      check("full_lvl", 32'(level_o), 1538);
      adv();
    end
    push_i = 1'b0;
    // Pop one: a read is granted next cycle, push space reappears the cycle after.
    out_rdy_i = 1'b1;
    @(negedge clk);
    check("pop0_dat", out_dat_o, 32'd0);
    check("pop0_rdy", 32'(push_rdy_o), 0);
    adv(); out_rdy_i = 1'b0;
    @(negedge clk);
    check("pop1_rd",  32'(ram_rd_ena_o), 1);
    check("pop1_rdy", 32'(push_rdy_o), 0);
    adv();
    @(negedge clk);
    check("pop2_rdy", 32'(push_rdy_o), 1);
    check("pop2_lvl", 32'(level_o), 1537);
    adv();
    drain(3000);

    // Backpressure with a full prefetch buffer.
    out_rdy_i = 1'b0;
    push_words(4, 32'h100, 1'b0, 50);
    repeat (6) adv();
    for (int i = 0; i < 10; i++) begin
      push_i = 1'b1; push_dat_i = 32'h200 + 32'(i);
      @(negedge clk);
      check("bp_val", 32'(out_val_o), 1);
      check("bp_dat", out_dat_o, 32'h100);
      check("bp_rd",  32'(ram_rd_ena_o), 0);
      check("bp_rdy", 32'(push_rdy_o), 1);
      adv();
    end
    push_i = 1'b0;
    drain(200);

    // Contention around half full: writes and reads alternate.
    out_rdy_i = 1'b0;
    push_words(770, 32'h1000, 1'b0, 2000);
    out_rdy_i = 1'b1;
    prev_wr = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      push_i = 1'b1; push_dat_i = 32'h5000 + 32'(k);
      @(negedge clk);
      if (i >= 10) check("alt_xor", 32'(ram_wr_ena_o ^ ram_rd_ena_o), 1);
      if (i >= 11) check("alt_tog", 32'(ram_wr_ena_o), 32'(!prev_wr));
      prev_wr = ram_wr_ena_o;
      if (push_rdy_o) k++;
      adv();
    end
    push_i = 1'b0;
    drain(3000);

    // Reset while a read is in flight.
    out_rdy_i = 1'b0;
    push_words(3, 32'h300, 1'b0, 50);
    adv();
    #2 rst = 1'b1;
    #1;
    check("mrst_val", 32'(out_val_o), 0);
    check("mrst_lvl", 32'(level_o), 0);
    check("mrst_rdy", 32'(push_rdy_o), 1);
    check("mrst_rd",  32'(ram_rd_ena_o), 0);
    @(negedge clk);
    adv();
    rst = 1'b0;
    out_rdy_i = 1'b1;
    push_words(1, 32'h1234, 1'b0, 10);
    k = 0;
    @(negedge clk);
    while (!out_val_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("mrst_first", out_dat_o, 32'h1234);
    adv();
    drain(50);

    // Long random-consumer run; pointers wrap several times.
    push_words(4000, 32'h10000, 1'b1, 20000);
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
